ac_gain_meter: RTL

//  Downstream of the op-amp gain stage: consumes paired ADC samples of stimulus (Input) and response (Output).

---
 rtl/ac_gain_meter_pkg.sv | 17 +
 rtl/gain_div_seq.sv | 73 +++++++
 rtl/ac_gain_meter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ac_gain_meter_pkg.sv
// Shared types, default sizes and helpers for the AC gain meter.
package ac_gain_meter_pkg;

  localparam int unsigned DW       = 16;
  localparam int unsigned WIN_LOG2 = 10;
  localparam int unsigned ACC_W    = DW + WIN_LOG2;
  localparam int unsigned GW       = 16;
  localparam int unsigned QF       = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_e;

  // Magnitude of a signed sample; the most negative value maps to 2**(DW-1) exactly.
  function automatic logic [DW-1:0] absval(input logic [DW-1:0] x);
    return x[DW-1] ? DW'(-x) : x;
  endfunction

endpackage

// File: rtl/gain_div_seq.sv
// Sequential restoring divider, one quotient bit per cycle MSB first.
// The caller guarantees num >> QW < den so the quotient fits in QW bits.
module gain_div_seq #(
  parameter int unsigned NW   = 28,
  parameter int unsigned DENW = 20,
  parameter int unsigned QW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NW-1:0]   num,
  input  logic [DENW-1:0] den,
  output logic            busy,
  output logic            done,
  output logic [QW-1:0]   quo
);

  localparam int unsigned CW = $clog2(QW + 1);

  logic [DENW-1:0] den_q;
  logic [DENW-1:0] rem_q;
  logic [QW-1:0]   nlo_q;
  logic [CW-1:0]   cnt_q;

  logic [DENW-1:0] rem_src_c;
  logic [DENW-1:0] den_src_c;
  logic [DENW-1:0] rem_new_c;
  logic            bit_src_c;
  logic [DENW:0]   trial_c;
  logic            ge_c;

  // The start cycle already produces the first quotient bit from the numerator's upper part.
  always_comb begin
    rem_src_c = start ? DENW'(num[NW-1:QW]) : rem_q;
    bit_src_c = start ? num[QW-1] : nlo_q[QW-1];
    den_src_c = start ? den : den_q;
    trial_c   = {rem_src_c, bit_src_c};
    ge_c      = (trial_c >= {1'b0, den_src_c});
    rem_new_c = ge_c ? DENW'(trial_c - {1'b0, den_src_c}) : trial_c[DENW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      den_q <= '0;
      rem_q <= '0;
      nlo_q <= '0;
      cnt_q <= '0;
      quo   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        den_q <= den;
        rem_q <= rem_new_c;
        nlo_q <= num[QW-1:0] << 1;
        quo   <= QW'(ge_c);
        cnt_q <= CW'(QW - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_new_c;
        nlo_q <= nlo_q << 1;
        quo   <= {quo[QW-2:0], ge_c};
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ac_gain_meter.sv
// Windowed |out|/|in| gain meter in UQ(GW-QF).QF fixed point.
// Define AC_GAIN_CLIP_DET_EN to enable full-scale clip detection on the clip output.
module ac_gain_meter #(
  parameter int unsigned DW       = 16,
  parameter int unsigned WIN_LOG2 = 10,
  parameter int unsigned GW       = 16,
  parameter int unsigned QF       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_smp,
  input  logic [DW-1:0] out_smp,
  output logic          busy,
  output logic          done,
  output logic [GW-1:0] gain,
  output logic          div_zero,
  output logic          sat,
  output logic          clip
);

  import ac_gain_meter_pkg::*;

  localparam int unsigned AW = DW + WIN_LOG2;
  localparam int unsigned NW = AW + QF;
  localparam int unsigned SW = AW + GW - QF;
  localparam int unsigned CW = WIN_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << WIN_LOG2) - 1);

  state_e        state_q;
  logic [AW-1:0] acc_in_q;
  logic [AW-1:0] acc_out_q;
  logic [CW-1:0] cnt_q;
  logic          pend_dz_q;
  logic          pend_sat_q;

  logic          acc_en_c;
  logic          div_first_c;
  logic          zero_c;
  logic          sat_c;
  logic          div_start_c;
  logic [NW-1:0] num_c;
  logic          div_busy;
  logic          div_done;
  logic [GW-1:0] div_quo;

  // First DIVIDE cycle is the one where the divider has neither started nor finished.
  assign acc_en_c    = (state_q == ACCUM) && in_valid;
  assign div_first_c = (state_q == DIVIDE) && !div_busy && !div_done;
  assign zero_c      = (acc_in_q == '0);
  assign sat_c       = (SW'(acc_out_q) >= (SW'(acc_in_q) << (GW - QF)));
  assign div_start_c = div_first_c && !zero_c && !sat_c;
  assign num_c       = NW'(acc_out_q) << QF;

  gain_div_seq #(
    .NW  (NW),
    .DENW(AW),
    .QW  (GW)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(div_start_c),
    .num  (num_c),
    .den  (acc_in_q),
    .busy (div_busy),
    .done (div_done),
    .quo  (div_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_in_q   <= '0;
      acc_out_q  <= '0;
      cnt_q      <= '0;
      pend_dz_q  <= 1'b0;
      pend_sat_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gain       <= '0;
      div_zero   <= 1'b0;
      sat        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            acc_in_q  <= '0;
            acc_out_q <= '0;
            cnt_q     <= '0;
            busy      <= 1'b1;
            state_q   <= ACCUM;
          end
        end
        ACCUM: begin
          if (acc_en_c) begin
            acc_in_q  <= acc_in_q + AW'(absval(in_smp));
            acc_out_q <= acc_out_q + AW'(absval(out_smp));
            cnt_q     <= cnt_q + CW'(1);
            if (cnt_q == LAST) state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (div_first_c) begin
            pend_dz_q  <= zero_c;
            pend_sat_q <= !zero_c && sat_c;
            if (zero_c || sat_c) state_q <= DONE;
          end else if (div_done) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          div_zero <= pend_dz_q;
          sat      <= pend_sat_q;
          gain     <= (pend_dz_q || pend_sat_q) ? '1 : div_quo;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AC_GAIN_CLIP_DET_EN
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  logic clip_seen_q;
  logic clip_q;
  logic hit_c;

  assign hit_c = (in_smp == SMAX) || (in_smp == SMIN) ||
                 (out_smp == SMAX) || (out_smp == SMIN);

  // Sticky full-scale flag over the window, published together with gain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_seen_q <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && start) clip_seen_q <= 1'b0;
      else if (acc_en_c && hit_c)  clip_seen_q <= 1'b1;
      if (state_q == DONE) clip_q <= clip_seen_q;
    end
  end

  assign clip = clip_q;
`else
  assign clip = 1'b0;
`endif

endmodule
